// File: rtl/datapath_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_seq_pkg                                                      |
// | Shared state encoding, opcode/ALUop constants and field positions.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_IMM    = 3'd2,
    S_GETA   = 3'd3,
    S_GETB   = 3'd4,
    S_EXEC   = 3'd5,
    S_WRB    = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM_W   = 8;

  // Every ALU op pair is legal; only two MOV op pairs exist.
  function automatic logic is_legal(input logic [15:0] ins);
    logic [2:0] opc;
    logic [1:0] op;
    opc = ins[OPC_LSB +: 3];
    op  = ins[OP_LSB +: 2];
    return (opc == OPC_ALU) ||
           ((opc == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode                                                          |
// | Field split, sign-extended immediate and class flags of an instr.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_decode
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [1:0]        sh,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] imm_sext,
  output logic              legal,
  output logic              is_mov_imm,
  output logic              is_mov_reg,
  output logic              is_cmp,
  output logic              uses_a
);

  logic [2:0] w_opc;

  assign w_opc    = ir[OPC_LSB +: 3];
  assign op       = ir[OP_LSB +: 2];
  assign rn       = ir[RN_LSB +: 3];
  assign rd       = ir[RD_LSB +: 3];
  assign sh       = ir[SH_LSB +: 2];
  assign rm       = ir[RM_LSB +: 3];
  assign imm_sext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  assign legal      = is_legal(ir);
  assign is_mov_imm = (w_opc == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (w_opc == OPC_MOV) && (op == OP_MOV_REG);
  assign is_cmp     = (w_opc == OPC_ALU) && (op == ALU_CMP);
  assign uses_a     = (w_opc == OPC_ALU) &&
                      ((op == ALU_ADD) || (op == ALU_CMP) || (op == ALU_AND));

endmodule
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_seq                                                          |
// | Multi-cycle sequencer driving the lab datapath control strobes.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic [15:0]       instr,
  output logic              w,
  output logic              done,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
  output logic [DATA_W-1:0] datapath_in
);

  state_t      r_state;
  logic [15:0] r_ir;

  logic [2:0] w_rn, w_rd, w_rm;
  logic [1:0] w_sh, w_op;
  logic       w_legal, w_mov_imm, w_mov_reg, w_cmp, w_uses_a;

  instr_decode #(.DATA_W(DATA_W)) u_dec (
    .ir         (r_ir),
    .rn         (w_rn),
    .rd         (w_rd),
    .rm         (w_rm),
    .sh         (w_sh),
    .op         (w_op),
    .imm_sext   (datapath_in),
    .legal      (w_legal),
    .is_mov_imm (w_mov_imm),
    .is_mov_reg (w_mov_reg),
    .is_cmp     (w_cmp),
    .uses_a     (w_uses_a)
  );

  // Outputs are registered for the state being entered, so each edge
  // computes the next state and that state's output vector together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_ir     <= '0;
      w        <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      shift    <= '0;
      ALUop    <= '0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
    end else begin
      w        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      shift    <= '0;
      ALUop    <= '0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (s) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
            err     <= !is_legal(instr);
          end else begin
            w <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_state <= S_WAIT;
            w       <= 1'b1;
          end else if (w_mov_imm) begin
            r_state  <= S_IMM;
            writenum <= w_rn;
            vsel     <= 1'b1;
            write    <= 1'b1;
            done     <= 1'b1;
          end else if (w_uses_a) begin
            r_state <= S_GETA;
            readnum <= w_rn;
            loada   <= 1'b1;
          end else begin
            r_state <= S_GETB;
            readnum <= w_rm;
            loadb   <= 1'b1;
          end
        end
        S_GETA: begin
          r_state <= S_GETB;
          readnum <= w_rm;
          loadb   <= 1'b1;
        end
        S_GETB: begin
          r_state <= S_EXEC;
          shift   <= w_sh;
          asel    <= w_mov_reg;
          ALUop   <= w_mov_reg ? ALU_ADD : w_op;
          if (w_cmp) begin
            loads <= 1'b1;
            done  <= 1'b1;
          end else begin
            loadc <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_cmp) begin
            r_state <= S_WAIT;
            w       <= 1'b1;
          end else begin
            r_state  <= S_WRB;
            writenum <= w_rd;
            write    <= 1'b1;
            done     <= 1'b1;
          end
        end
        default: begin
          r_state <= S_WAIT;
          w       <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_datapath_seq                                                       |
// | Scoreboard bench: per-cycle expected outputs from a reference model.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_datapath_seq;

  typedef struct packed {
    logic        w;
    logic        done;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    logic [15:0] dp;
  } outv_t;

  typedef struct packed {
    int    tag;
    outv_t v;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n, s;
  logic [15:0] instr;
  logic        w, done, err, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, alu_op;
  logic [15:0] datapath_in;

  outv_t act;
  rec_t  exp_q[$];
  rec_t  rec;
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;
  int    id = 0;

  always #5 clk = ~clk;

  datapath_seq #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
    .w(w), .done(done), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(alu_op), .loadc(loadc), .loads(loads),
    .datapath_in(datapath_in)
  );

  assign act = {w, done, err, readnum, writenum, write, vsel, loada, loadb,
                asel, bsel, shift, alu_op, loadc, loads, datapath_in};

  // Monitor: one expected record per cycle while an instruction is in flight.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        rec = exp_q.pop_front();
        n_cmp++;
        if (act !== rec.v) begin
          n_fail++;
          $display("FAIL seq instr%0d step%0d actual=%h required=%h",
                   rec.tag / 16, rec.tag % 16, act, rec.v);
        end
      end else begin
        n_cmp++;
        if (!(w === 1'b1 &&
              {done, err, write, loada, loadb, loadc, loads} === 7'b0)) begin
          n_fail++;
          $display("FAIL idle actual w=%b strobes=%b required w=1 strobes=0",
                   w, {done, err, write, loada, loadb, loadc, loads});
        end
      end
    end
  end

  // Reference model: the cycle-by-cycle output list implied by the
  // instruction class, ending with the return to WAIT.
  task automatic push_model(input logic [15:0] ins, input int tid,
                            input int keep, output int lat);
    outv_t q[$];
    outv_t z, r;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic signed [7:0] imm;
    int   v;
    logic legal, mov_imm, mov_reg, cmp, alu;
    rec_t rr;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
    imm = ins[7:0];
    v = imm;
    alu     = (opc == 3'b101);
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    cmp     = alu && (op == 2'b01);
    legal   = alu || mov_imm || mov_reg;
    z = '0;
    z.dp = v[15:0];
    r = z; r.err = !legal; q.push_back(r);
    if (legal) begin
      if (mov_imm) begin
        r = z; r.writenum = rn; r.vsel = 1; r.write = 1; r.done = 1; q.push_back(r);
      end else begin
        if (alu && op != 2'b11) begin
          r = z; r.readnum = rn; r.loada = 1; q.push_back(r);
        end
        r = z; r.readnum = rm; r.loadb = 1; q.push_back(r);
        r = z; r.shift = sh; r.asel = mov_reg; r.aluop = mov_reg ? 2'b00 : op;
        if (cmp) begin r.loads = 1; r.done = 1; end else r.loadc = 1;
        q.push_back(r);
        if (!cmp) begin
          r = z; r.writenum = rd; r.write = 1; r.done = 1; q.push_back(r);
        end
      end
    end
    r = z; r.w = 1; q.push_back(r);
    lat = q.size() - 1;
    for (int i = 0; i < q.size(); i++) begin
      if (keep == 0 || i < keep) begin
        rr.tag = tid * 16 + i;
        rr.v   = q[i];
        exp_q.push_back(rr);
      end
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic noisy);
    int lat;
    s = 1'b1; instr = ins;
    @(posedge clk); #1;
    push_model(ins, id, 0, lat);
    id++;
    s = 1'b0;
    repeat (lat) begin
      if (noisy) begin
        s = 1'($urandom);
        instr = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    s = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] x;
    int k;
    x = 16'($urandom);
    k = int'($urandom_range(0, 6));
    case (k)
      0: x[15:11] = 5'b11010;
      1: x[15:11] = 5'b11000;
      2: x[15:11] = 5'b10100;
      3: x[15:11] = 5'b10101;
      4: x[15:11] = 5'b10110;
      5: x[15:11] = 5'b10111;
      default: begin
        while (x[15:13] == 3'b101 ||
               (x[15:13] == 3'b110 && (x[12:11] == 2'b10 || x[12:11] == 2'b00)))
          x = 16'($urandom);
      end
    endcase
    return x;
  endfunction

  initial begin
    int dummy;
    rec_t rr;
    outv_t wr;
    rst_n = 1'b0; s = 1'b0; instr = 16'h0;
    @(posedge clk); #1;
    wr = '0; wr.w = 1'b1;
    rr.tag = 0; rr.v = wr;
    exp_q.push_back(rr);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'hD07F, 1'b0);
    issue(16'hD080, 1'b0);
    issue(16'hA148, 1'b0);
    issue(16'hAB04, 1'b0);
    issue(16'hC0A6, 1'b0);
    issue(16'hB8E1, 1'b0);
    issue(16'hE000, 1'b0);
    issue(16'hA148, 1'b1);

    // Abort an ADD in EXEC, then hold reset with s high.
    s = 1'b1; instr = 16'hA148;
    @(posedge clk); #1;
    push_model(16'hA148, id, 4, dummy);
    id++;
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; s = 1'b1; instr = 16'hD07F;
    for (int i = 0; i < 2; i++) begin
      rr.tag = id * 16 + i; rr.v = wr;
      exp_q.push_back(rr);
    end
    id++;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; s = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      issue(rand_instr(), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Multi-cycle control FSM that sequences the lab datapath (register file, A/B/C regs, shifter, ALU, status) so software-visible instructions execute without manual switch stepping.
- Accepts one 16-bit instruction per start/wait handshake.
- Decodes the instruction and drives readnum/writenum/loada/loadb/asel/bsel/shift/ALUop/loadc/loads/vsel/write cycle by cycle.
- Sits between the instruction source (switch interface now, instruction register later) and the datapath.

Parameters:
- DATA_W, 16, datapath word width; the sign-extended immediate is DATA_W bits.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- s, in, 1, start request; sampled only in WAIT.
- instr, in, 16, instruction; sampled together with s.
- w, out, 1, ready/idle; high only in WAIT.
- done, out, 1, one-cycle pulse in the final state of a legal instruction.
- err, out, 1, one-cycle pulse in DECODE when the opcode/op pair is illegal.
- readnum, out, 3, register file read address.
- writenum, out, 3, register file write address.
- write, out, 1, register file write enable.
- vsel, out, 1, writeback select: 1 = datapath_in, 0 = C.
- loada, out, 1, load A register.
- loadb, out, 1, load B register.
- asel, out, 1, 1 forces ALU A input to 0.
- bsel, out, 1, 1 selects datapath_in on the B side.
- shift, out, 2, shifter control.
- ALUop, out, 2, ALU operation.
- loadc, out, 1, load C register.
- loads, out, 1, load status register.
- datapath_in, out, DATA_W, sign-extended imm8.

Behaviour:
- Instruction fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0]. All fields are latched into an internal instruction register on accept.
- Legal opcode/op pairs: 110/10 MOV_IMM; 110/00 MOV_REG; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. Every other pair is illegal.
- Accept: in WAIT, s=1 at a rising edge latches instr and moves to DECODE. s is ignored in every other state; holding s high after returning to WAIT starts a new instruction.
- States: WAIT, DECODE, IMM, GETA, GETB, EXEC, WRB. Outputs are Moore, decoded from state plus the latched fields. Every signal not listed for a state is 0.
- WAIT: w=1.
- DECODE: err=1 if illegal. Next state: illegal→WAIT; MOV_IMM→IMM; ADD, CMP, AND→GETA; MOV_REG, MVN→GETB.
- IMM: writenum=Rn, vsel=1, write=1, done=1. Next: WAIT.
- GETA: readnum=Rn, loada=1. Next: GETB.
- GETB: readnum=Rm, loadb=1. Next: EXEC.
- EXEC: shift=sh, bsel=0, ALUop=op; asel=1 and ALUop=00 for MOV_REG.
  - CMP: loads=1, loadc=0, done=1, next WAIT.
  - All others: loadc=1, loads=0, next WRB.
- WRB: writenum=Rd, vsel=0, write=1, done=1. Next: WAIT.
- Latency, accept edge to w=1: MOV_IMM 2 cycles; CMP, MVN and MOV_REG 4; ADD and AND 5; illegal 1.
- datapath_in = sign-extended imm8 from the latched register. It is held stable in every state, not only IMM.
- Reset: rst_n=0 at an edge forces WAIT and clears the instruction register to 0. w=1, all other outputs 0. Reset mid-instruction aborts it with no further write/load strobes and no done pulse. Reset dominates s.
- No strobe (write/loada/loadb/loadc/loads) is asserted for more than one cycle per instruction, except readnum, which is a level.

Decomposition:
- Package datapath_seq_pkg holds:
  - state enum encoding (3 bits);
  - opcode constants (OPC_MOV=110, OPC_ALU=101);
  - ALUop constants (ADD=00, CMP=01, AND=10, MVN=11);
  - field bit-position localparams.
- One combinational sub-module, instr_decode: splits the latched instruction into fields, produces the sign-extended immediate and the legal/class flags. The FSM module instantiates it.

Test Plan:
- MOV_IMM instr=16'hD07F (R0,#127), s pulse → IMM cycle with writenum=0, vsel=1, write=1, datapath_in=16'h007F; w=1 two cycles after accept. Repeat with imm8=8'h80 → datapath_in=16'hFF80.
- ADD R2,R1,R0 LSL#1 (16'hA148) → GETA readnum=1/loada, GETB readnum=0/loadb, EXEC shift=01/ALUop=00/loadc, WRB writenum=2/write; done pulses exactly once; w returns after 5 cycles.
- CMP R3,R4 (16'hAB04) → EXEC has loads=1 and loadc=0, no write strobe in any cycle, done in EXEC, latency 4.
- MOV_REG R5,R6 (16'hC0A6) and MVN R7,R1 (16'hB8E1) → no GETA; EXEC asel=1/ALUop=00 for MOV_REG and asel=0/ALUop=11 for MVN; write to Rd.
- Illegal instr=16'hE000 → err pulse in DECODE, back to WAIT after 1 cycle, zero strobes; s toggled during a busy ADD is ignored.
- rst_n low during EXEC of ADD → next cycle WAIT, w=1, no WRB write, no done; rst_n low with s=1 → remains in WAIT.
